// File: rtl/rs_pkg.sv
// Shared GF(2^5) definitions for the RS decoder: symbol type, field polynomial
// and the polynomial-basis multiplier/adder used by the decoder datapaths.
package rs_pkg;
  localparam int GF_W = 5;
  localparam logic [GF_W-1:0] GF_POLY = 5'h05;  // x^5 = x^2 + 1

  typedef logic [GF_W-1:0] gf_sym_t;

  function automatic gf_sym_t gf_xtime(input gf_sym_t v);
    return {v[GF_W-2:0], 1'b0} ^ (v[GF_W-1] ? GF_POLY : gf_sym_t'(0));
  endfunction

  // Horner form: walk b from its MSB, doubling the partial product each step.
  function automatic gf_sym_t gf_mul(input gf_sym_t a, input gf_sym_t b);
    gf_sym_t r;
    r = '0;
    for (int i = GF_W - 1; i >= 0; i--)
      r = gf_xtime(r) ^ (b[i] ? a : gf_sym_t'(0));
    return r;
  endfunction

  function automatic gf_sym_t gf_add(input gf_sym_t a, input gf_sym_t b);
    return a ^ b;
  endfunction
endpackage

// File: rtl/gf32_mac.sv
// Combinational GF(2^5) multiply-accumulate: y = a*b + c.
module gf32_mac
  import rs_pkg::*;
(
  input  gf_sym_t a,
  input  gf_sym_t b,
  input  gf_sym_t c,
  output gf_sym_t y
);
  assign y = gf_add(gf_mul(a, b), c);
endmodule

// File: rtl/gf_mac_arbiter.sv
// Round-robin time-shared GF(2^5) MAC: NREQ requesters, valid/ready request side,
// 2-stage pipeline with tagged, non-backpressured responses.
module gf_mac_arbiter
  import rs_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [GF_W*NREQ-1:0] req_a,
  input  logic [GF_W*NREQ-1:0] req_b,
  input  logic [GF_W*NREQ-1:0] req_c,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output gf_sym_t              rsp_data,
  output logic                 busy
);
  logic [IDW-1:0] ptr, gnt_id, idx;
  logic           gnt;
  logic           s1_v;
  logic [IDW-1:0] s1_id;
  gf_sym_t        s1_a, s1_b, s1_c, mac_y;

  // First valid requester at or after ptr; reset_n gating keeps ready low in reset.
  always_comb begin
    req_ready = '0;
    gnt       = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    if (enable && reset_n) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = IDW'((int'(ptr) + k) % NREQ);
        if (!gnt && req_valid[idx]) begin
          gnt            = 1'b1;
          gnt_id         = idx;
          req_ready[idx] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr   <= '0;
      s1_v  <= 1'b0;
      s1_id <= '0;
      s1_a  <= '0;
      s1_b  <= '0;
      s1_c  <= '0;
    end else begin
      s1_v <= gnt;
      if (gnt) begin
        ptr   <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        s1_id <= gnt_id;
        s1_a  <= req_a[GF_W*gnt_id +: GF_W];
        s1_b  <= req_b[GF_W*gnt_id +: GF_W];
        s1_c  <= req_c[GF_W*gnt_id +: GF_W];
      end
    end
  end

  gf32_mac u_mac (
    .a(s1_a),
    .b(s1_b),
    .c(s1_c),
    .y(mac_y)
  );

  // busy is registered as the OR of the next-state stage valids.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= s1_v;
      busy      <= gnt | s1_v;
      if (s1_v) begin
        rsp_id   <= s1_id;
        rsp_data <= mac_y;
      end
    end
  end
endmodule

// File: tb/tb_gf_mac_arbiter.sv
// Directed self-checking bench for gf_mac_arbiter with a carry-less reference model.
module tb_gf_mac_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              enable;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [5*NREQ-1:0] req_a, req_b, req_c;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [4:0]        rsp_data;
  logic              busy;
  int                total = 0;
  int                bad = 0;

  gf_mac_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clock = ~clock;

  // Full 9-bit carry-less product, then fold x^8..x^5 back with x^5+x^2+1.
  function automatic logic [4:0] gf_ref(input logic [4:0] a, input logic [4:0] b,
                                        input logic [4:0] c);
    logic [8:0] p;
    p = '0;
    for (int i = 0; i < 5; i++)
      if (b[i]) p = p ^ (9'(a) << i);
    for (int k = 8; k >= 5; k--)
      if (p[k]) p = p ^ (9'h025 << (k - 5));
    return p[4:0] ^ c;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input int i, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] c);
    req_a[5*i +: 5] = a;
    req_b[5*i +: 5] = b;
    req_c[5*i +: 5] = c;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b1; req_valid = '1;
    req_a = '0; req_b = '0; req_c = '0;
    tick(); tick();
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    total++; if (rsp_id !== 2'd0 || rsp_data !== 5'h00) begin bad++; $display("FAIL reset_rsp got id=%0d data=%h want 0/00", rsp_id, rsp_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    req_valid = '0;
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    set_op(0, 5'h02, 5'h10, 5'h00);
    req_valid = 4'b0001;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b want=0001", req_ready); end
    tick();
    req_valid = '0;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL single_s1 got v=%b busy=%b want 0/1", rsp_valid, busy); end
    tick();
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 5'h05) begin bad++; $display("FAIL single_rsp got v=%b id=%0d data=%h want 1/0/05", rsp_valid, rsp_id, rsp_data); end
    tick();
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_idle got v=%b busy=%b want 0/0", rsp_valid, busy); end
  endtask

  task automatic test_req2();
    set_op(2, 5'h10, 5'h10, 5'h0D);
    req_valid = 4'b0100;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL req2_ready0 got=%b want=0100", req_ready); end
    tick();
    set_op(2, 5'h02, 5'h12, 5'h00);
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL req2_ready1 got=%b want=0100", req_ready); end
    tick();
    req_valid = '0;
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 5'h00) begin bad++; $display("FAIL req2_rsp0 got v=%b id=%0d data=%h want 1/2/00", rsp_valid, rsp_id, rsp_data); end
    tick();
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 5'h01) begin bad++; $display("FAIL req2_rsp1 got v=%b id=%0d data=%h want 1/2/01", rsp_valid, rsp_id, rsp_data); end
    tick();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL req2_idle got v=%b want 0", rsp_valid); end
  endtask

  task automatic test_all_rr();
    logic [3:0] want;
    int g;
    reset_n = 1'b0; #1; reset_n = 1'b1;   // ptr back to 0
    for (int i = 0; i < NREQ; i++) set_op(i, 5'(i + 1), 5'h03, 5'(i));
    for (int cyc = 0; cyc < 14; cyc++) begin
      req_valid = (cyc < 12) ? 4'b1111 : 4'b0000;
      #1;
      want = (cyc < 12) ? 4'(1 << (cyc % 4)) : 4'b0000;
      total++; if (req_ready !== want) begin bad++; $display("FAIL rr_ready cyc=%0d got=%b want=%b", cyc, req_ready, want); end
      if (cyc >= 2) begin
        g = (cyc - 2) % 4;
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'(g) || rsp_data !== gf_ref(5'(g + 1), 5'h03, 5'(g))) begin
          bad++; $display("FAIL rr_rsp cyc=%0d got v=%b id=%0d data=%h want 1/%0d/%h", cyc, rsp_valid, rsp_id, rsp_data, g, gf_ref(5'(g + 1), 5'h03, 5'(g)));
        end
      end
      tick();
    end
  endtask

  task automatic test_ptr_skip();
    logic [3:0] seq [3];
    seq[0] = 4'b0010; seq[1] = 4'b1000; seq[2] = 4'b0010;
    set_op(1, 5'h01, 5'h07, 5'h00);
    set_op(3, 5'h01, 5'h09, 5'h00);
    req_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (req_ready !== seq[k]) begin bad++; $display("FAIL skip_ready k=%0d got=%b want=%b", k, req_ready, seq[k]); end
      tick();
    end
    req_valid = '0;
    #1;
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 5'h09) begin bad++; $display("FAIL skip_rsp3 got v=%b id=%0d data=%h want 1/3/09", rsp_valid, rsp_id, rsp_data); end
    tick();
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 5'h07) begin bad++; $display("FAIL skip_rsp1 got v=%b id=%0d data=%h want 1/1/07", rsp_valid, rsp_id, rsp_data); end
    tick();
  endtask

  task automatic test_enable_drop();
    set_op(0, 5'h03, 5'h03, 5'h00);
    req_valid = 4'b0001;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL en_ready0 got=%b want=0001", req_ready); end
    tick();
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL en_ready1 got=%b want=0001", req_ready); end
    tick();
    enable = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL en_off_ready got=%b want=0000", req_ready); end
    total++; if (rsp_valid !== 1'b1 || rsp_data !== 5'h05 || busy !== 1'b1) begin bad++; $display("FAIL en_rsp0 got v=%b data=%h busy=%b want 1/05/1", rsp_valid, rsp_data, busy); end
    tick();
    total++; if (rsp_valid !== 1'b1 || rsp_data !== 5'h05 || req_ready !== 4'b0000) begin bad++; $display("FAIL en_rsp1 got v=%b data=%h ready=%b want 1/05/0000", rsp_valid, rsp_data, req_ready); end
    tick();
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL en_drain got v=%b busy=%b want 0/0", rsp_valid, busy); end
    req_valid = '0;
    enable = 1'b1;
  endtask

  task automatic test_async_reset();
    set_op(3, 5'h1F, 5'h1F, 5'h01);
    req_valid = 4'b1000;
    tick(); tick();
    total++; if (busy !== 1'b1 || rsp_valid !== 1'b1) begin bad++; $display("FAIL ar_full got busy=%b v=%b want 1/1", busy, rsp_valid); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL ar_now got v=%b busy=%b want 0/0", rsp_valid, busy); end
    total++; if (rsp_id !== 2'd0 || rsp_data !== 5'h00 || req_ready !== 4'b0000) begin bad++; $display("FAIL ar_vals got id=%0d data=%h ready=%b want 0/00/0000", rsp_id, rsp_data, req_ready); end
    req_valid = '0;
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL ar_stale k=%0d got v=%b busy=%b want 0/0", k, rsp_valid, busy); end
    end
  endtask

  task automatic test_exhaustive();
    int misses;
    int m;
    logic [4:0] ea, eb, ec, want;
    misses = 0;
    for (int n = 0; n < 32768 + 2; n++) begin
      if (n < 32768) begin
        set_op(NREQ - 1, 5'(n >> 10), 5'(n >> 5), 5'(n));
        req_valid = 4'b1000;
      end else begin
        req_valid = '0;
      end
      #1;
      if (n < 32768 && req_ready !== 4'b1000) misses++;
      if (n >= 2) begin
        m = n - 2;
        ea = 5'(m >> 10); eb = 5'(m >> 5); ec = 5'(m);
        want = gf_ref(ea, eb, ec);
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'(NREQ - 1) || rsp_data !== want) begin
          bad++; $display("FAIL exh a=%h b=%h c=%h got v=%b id=%0d data=%h want 1/%0d/%h", ea, eb, ec, rsp_valid, rsp_id, rsp_data, NREQ - 1, want);
        end
      end
      tick();
    end
    total++; if (misses !== 0) begin bad++; $display("FAIL exh_ready_every_cycle got misses=%0d want 0", misses); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_req2();
    test_all_rr();
    test_ptr_skip();
    test_enable_drop();
    test_async_reset();
    test_exhaustive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
